round_judge: RTL and testbench



---
 rtl/rps_pkg.sv | 31 +++
 rtl/round_judge_if.sv | 39 +++
 rtl/rps_referee.sv | 21 ++
 rtl/round_judge.sv | 165 ++++++++++++++++
 tb/tb_round_judge.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rps_pkg.sv
// Shared definitions for the rock-paper-scissors round controller:
// move encodings, outcome codes, controller states and the "who beats whom" rule.
package rps_pkg;

    localparam logic [1:0] MV_ROCK    = 2'b00;
    localparam logic [1:0] MV_SCISSOR = 2'b01;
    localparam logic [1:0] MV_PAPER   = 2'b10;
    localparam logic [1:0] MV_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        OUT_DRAW   = 2'b00,
        OUT_PLAYER = 2'b01,
        OUT_AI     = 2'b10
    } outcome_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_AI = 3'd1,
        ST_JUDGE   = 3'd2,
        ST_REPORT  = 3'd3,
        ST_OVER    = 3'd4
    } state_t;

    // True when move a defeats move b: rock>scissor, scissor>paper, paper>rock.
    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        beats = ((a == MV_ROCK)    && (b == MV_SCISSOR)) ||
                ((a == MV_SCISSOR) && (b == MV_PAPER))   ||
                ((a == MV_PAPER)   && (b == MV_ROCK));
    endfunction

endpackage

// File: rtl/round_judge_if.sv
// Bundle of player-side, AI-handshake and scoreboard signals around round_judge.
// The master modport is the judge itself; the slave modport is its surroundings
// (top-level switches/keys, AI predictor and display logic).
interface round_judge_if #(
    parameter int SCORE_W = 8
);

    logic               commit;
    logic               new_game;
    logic [1:0]         player_move;
    logic               ai_req;
    logic [1:0]         ai_choice;
    logic               ai_valid;
    logic [3:0]         combination;
    logic               comb_valid;
    logic [1:0]         outcome;
    logic [SCORE_W-1:0] player_score;
    logic [SCORE_W-1:0] ai_score;
    logic [SCORE_W-1:0] draw_count;
    logic [SCORE_W-1:0] round_count;
    logic               illegal_move;
    logic               ai_timeout;
    logic               game_over;

    modport master (
        input  commit, new_game, player_move, ai_choice, ai_valid,
        output ai_req, combination, comb_valid, outcome,
               player_score, ai_score, draw_count, round_count,
               illegal_move, ai_timeout, game_over
    );

    modport slave (
        output commit, new_game, player_move, ai_choice, ai_valid,
        input  ai_req, combination, comb_valid, outcome,
               player_score, ai_score, draw_count, round_count,
               illegal_move, ai_timeout, game_over
    );

endinterface

// File: rtl/rps_referee.sv
// Combinational referee: decides a round from the player's and the AI's move.
// Kept separate so the display logic can reuse the same decision.
module rps_referee
    import rps_pkg::*;
(
    input  logic [1:0] i_playerMove,
    input  logic [1:0] i_aiMove,
    output outcome_t   o_outcome
);

    // Equal moves draw, a beating player move wins, everything else goes to the AI.
    always_comb begin
        o_outcome = OUT_AI;
        if (i_playerMove == i_aiMove) begin
            o_outcome = OUT_DRAW;
        end else if (beats(i_playerMove, i_aiMove)) begin
            o_outcome = OUT_PLAYER;
        end
    end

endmodule

// File: rtl/round_judge.sv
// Round controller: captures a committed player move, fetches the AI move over a
// req/valid handshake (with a fallback on timeout), judges the round, keeps the
// saturating score counters and reports the {ai, player} combination to the learner.
module round_judge
    import rps_pkg::*;
#(
    parameter int SCORE_W    = 8,
    parameter int TARGET     = 10,
    parameter int AI_TIMEOUT = 16
) (
    input logic           clock,
    input logic           reset,
    round_judge_if.master bus
);

    localparam int TIMER_W = (AI_TIMEOUT > 2) ? $clog2(AI_TIMEOUT) : 1;

    state_t             r_state;
    state_t             w_nextState;
    logic               r_commitQ;
    logic [1:0]         r_pMv;
    logic [1:0]         r_aMv;
    logic [TIMER_W-1:0] r_timer;
    logic [SCORE_W-1:0] r_playerScore;
    logic [SCORE_W-1:0] r_aiScore;
    logic [SCORE_W-1:0] r_drawCount;
    logic [SCORE_W-1:0] r_roundCount;
    outcome_t           r_outcome;
    logic [3:0]         r_combination;
    logic               r_aiReq;
    logic               r_combValid;
    logic               r_illegal;
    logic               r_aiTimeout;

    logic               w_rise;
    logic               w_legalRise;
    logic               w_illegalRise;
    logic               w_aiAccept;
    logic               w_timedOut;
    logic               w_targetHit;
    outcome_t           w_judged;

    function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] v);
        satInc = (&v) ? v : v + 1'b1;
    endfunction

    assign w_rise        = bus.commit & ~r_commitQ;
    assign w_legalRise   = (r_state == ST_IDLE) && w_rise && (bus.player_move != MV_ILLEGAL);
    assign w_illegalRise = (r_state == ST_IDLE) && w_rise && (bus.player_move == MV_ILLEGAL);
    assign w_aiAccept    = (r_state == ST_WAIT_AI) && bus.ai_valid && (bus.ai_choice != MV_ILLEGAL);
    assign w_timedOut    = (r_state == ST_WAIT_AI) && !w_aiAccept &&
                           (r_timer == TIMER_W'(AI_TIMEOUT - 1));
    assign w_targetHit   = (r_playerScore == SCORE_W'(TARGET)) || (r_aiScore == SCORE_W'(TARGET));

    rps_referee u_referee (
        .i_playerMove (r_pMv),
        .i_aiMove     (r_aMv),
        .o_outcome    (w_judged)
    );

    // Previous commit level, so a level held high only ever starts one round.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_commitQ <= 1'b0;
        end else begin
            r_commitQ <= bus.commit;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; new_game aborts whatever is in flight and restarts in IDLE.
    always_comb begin
        w_nextState = r_state;
        if (bus.new_game) begin
            w_nextState = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:    if (w_legalRise) w_nextState = ST_WAIT_AI;
                ST_WAIT_AI: if (w_aiAccept || w_timedOut) w_nextState = ST_JUDGE;
                ST_JUDGE:   w_nextState = ST_REPORT;
                ST_REPORT:  w_nextState = w_targetHit ? ST_OVER : ST_IDLE;
                ST_OVER:    w_nextState = ST_OVER;
                default:    w_nextState = ST_IDLE;
            endcase
        end
    end

    // Move latches and the AI wait timer; a timeout substitutes rock for the AI.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pMv   <= MV_ROCK;
            r_aMv   <= MV_ROCK;
            r_timer <= '0;
        end else begin
            if (w_legalRise && !bus.new_game) begin
                r_pMv   <= bus.player_move;
                r_timer <= '0;
            end else if (r_state == ST_WAIT_AI) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_aiAccept) begin
                r_aMv <= bus.ai_choice;
            end else if (w_timedOut) begin
                r_aMv <= MV_ROCK;
            end
        end
    end

    // One-cycle event pulses; none of them survive a same-cycle new_game.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_aiReq     <= 1'b0;
            r_illegal   <= 1'b0;
            r_aiTimeout <= 1'b0;
            r_combValid <= 1'b0;
        end else begin
            r_aiReq     <= w_legalRise && !bus.new_game;
            r_illegal   <= w_illegalRise && !bus.new_game;
            r_aiTimeout <= w_timedOut && !bus.new_game;
            r_combValid <= (r_state == ST_JUDGE) && !bus.new_game;
        end
    end

    // Scoreboard: updated on leaving JUDGE so it lines up with comb_valid in REPORT.
    always_ff @(posedge clock) begin
        if (reset || bus.new_game) begin
            r_playerScore <= '0;
            r_aiScore     <= '0;
            r_drawCount   <= '0;
            r_roundCount  <= '0;
            r_outcome     <= OUT_DRAW;
            r_combination <= 4'b0000;
        end else if (r_state == ST_JUDGE) begin
            r_roundCount  <= satInc(r_roundCount);
            r_outcome     <= w_judged;
            r_combination <= {r_aMv, r_pMv};
            unique case (w_judged)
                OUT_PLAYER: r_playerScore <= satInc(r_playerScore);
                OUT_AI:     r_aiScore     <= satInc(r_aiScore);
                default:    r_drawCount   <= satInc(r_drawCount);
            endcase
        end
    end

    assign bus.ai_req       = r_aiReq;
    assign bus.illegal_move = r_illegal;
    assign bus.ai_timeout   = r_aiTimeout;
    assign bus.comb_valid   = r_combValid;
    assign bus.combination  = r_combination;
    assign bus.outcome      = r_outcome;
    assign bus.player_score = r_playerScore;
    assign bus.ai_score     = r_aiScore;
    assign bus.draw_count   = r_drawCount;
    assign bus.round_count  = r_roundCount;
    assign bus.game_over    = (r_state == ST_OVER);

endmodule

// File: tb/tb_round_judge.sv
// Scoreboard bench for round_judge: each round pushes its expected
// {combination, outcome} when the AI answer is driven and pops it at comb_valid.
module tb_round_judge;

    import rps_pkg::*;

    localparam int SCORE_W = 8;

    typedef struct packed {
        logic [3:0] comb;
        logic [1:0] outc;
    } exp_t;

    logic clock = 1'b0;
    logic reset;

    round_judge_if #(.SCORE_W(SCORE_W)) bus ();

    round_judge #(
        .SCORE_W    (SCORE_W),
        .TARGET     (10),
        .AI_TIMEOUT (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int   errors = 0;
    int   checks = 0;
    exp_t expQ[$];
    logic [SCORE_W-1:0] expPlayer, expAi, expDraw, expRound;
    int   cvCount = 0;
    int   aiReqCount = 0;

    // Count output pulses away from the active edge.
    always @(negedge clock) begin
        if (bus.comb_valid === 1'b1) cvCount++;
        if (bus.ai_req === 1'b1) aiReqCount++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got time %0t want < 100000", $time);
        $fatal(1);
    end

    // Reference rule: p wins when a is the move "one after" p in rock->scissor->paper->rock.
    function automatic logic [1:0] refOutcome(input logic [1:0] p, input logic [1:0] a);
        logic [1:0] victim;
        victim = (p == 2'd2) ? 2'd0 : p + 2'd1;
        if (p == a) return 2'b00;
        if (a == victim) return 2'b01;
        return 2'b10;
    endfunction

    task automatic clearModel();
        expPlayer = '0; expAi = '0; expDraw = '0; expRound = '0;
        expQ.delete();
    endtask

    task automatic pushRound(input logic [1:0] p, input logic [1:0] a);
        exp_t e;
        e.comb = {a, p};
        e.outc = refOutcome(p, a);
        expQ.push_back(e);
        expRound = expRound + 1'b1;
        case (e.outc)
            2'b00:   expDraw   = expDraw + 1'b1;
            2'b01:   expPlayer = expPlayer + 1'b1;
            default: expAi     = expAi + 1'b1;
        endcase
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    // Commit rise during cycle N; returns 1 time unit into cycle N+1.
    task automatic applyStimulus(input logic [1:0] mv);
        bus.commit = 1'b1;
        bus.player_move = mv;
        step(1);
        bus.commit = 1'b0;
    endtask

    task automatic answerAi(input logic [1:0] mv, input int delay);
        step(delay);
        bus.ai_valid = 1'b1;
        bus.ai_choice = mv;
        step(1);
        bus.ai_valid = 1'b0;
        bus.ai_choice = 2'b00;
    endtask

    task automatic waitComb(input int budget, output int waited);
        waited = 0;
        while (bus.comb_valid !== 1'b1 && waited < budget) begin
            step(1);
            waited++;
        end
    endtask

    task automatic pulseNewGame();
        bus.new_game = 1'b1;
        step(1);
        bus.new_game = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        clearModel();
        checks++;
        if ({bus.ai_req, bus.comb_valid, bus.illegal_move, bus.ai_timeout, bus.game_over,
             bus.combination, bus.outcome} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b want 0", {bus.ai_req, bus.comb_valid,
                     bus.illegal_move, bus.ai_timeout, bus.game_over, bus.combination, bus.outcome});
        end
        checks++;
        if ({bus.player_score, bus.ai_score, bus.draw_count, bus.round_count} !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_counters got %h want 0",
                     {bus.player_score, bus.ai_score, bus.draw_count, bus.round_count});
        end
    endtask

    task automatic test_first_round();
        int waited;
        exp_t e;
        applyStimulus(MV_ROCK);
        checks++;
        if (bus.ai_req !== 1'b1) begin
            errors++; $display("[TB] FAIL first_ai_req got %b want 1", bus.ai_req);
        end
        pushRound(MV_ROCK, MV_PAPER);
        answerAi(MV_PAPER, 0);
        checks++;
        if (bus.ai_req !== 1'b0) begin
            errors++; $display("[TB] FAIL first_ai_req_single got %b want 0", bus.ai_req);
        end
        waitComb(20, waited);
        checks++;
        if (waited != 1) begin
            errors++; $display("[TB] FAIL first_latency got %0d want 1 cycle after JUDGE", waited);
        end
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if ({bus.combination, bus.outcome} !== {e.comb, e.outc}) begin
                errors++;
                $display("[TB] FAIL first_result got comb=%b out=%b want comb=%b out=%b",
                         bus.combination, bus.outcome, e.comb, e.outc);
            end
        end
        checks++;
        if ({bus.player_score, bus.ai_score, bus.draw_count, bus.round_count} !==
            {expPlayer, expAi, expDraw, expRound}) begin
            errors++;
            $display("[TB] FAIL first_counters got p=%0d a=%0d d=%0d r=%0d want p=%0d a=%0d d=%0d r=%0d",
                     bus.player_score, bus.ai_score, bus.draw_count, bus.round_count,
                     expPlayer, expAi, expDraw, expRound);
        end
        step(1);
    endtask

    task automatic test_player_and_draw();
        int waited;
        exp_t e;
        logic [1:0] pMoves [2];
        logic [1:0] aMoves [2];
        pMoves[0] = MV_SCISSOR; aMoves[0] = MV_PAPER;
        pMoves[1] = MV_PAPER;   aMoves[1] = MV_PAPER;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(pMoves[i]);
            pushRound(pMoves[i], aMoves[i]);
            answerAi(aMoves[i], i + 1);
            waitComb(20, waited);
            checks++;
            if (bus.comb_valid !== 1'b1) begin
                errors++; $display("[TB] FAIL pd_comb_valid round %0d got 0 want 1", i);
            end
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checks++;
                if ({bus.combination, bus.outcome} !== {e.comb, e.outc}) begin
                    errors++;
                    $display("[TB] FAIL pd_result round %0d got comb=%b out=%b want comb=%b out=%b",
                             i, bus.combination, bus.outcome, e.comb, e.outc);
                end
            end
            step(1);
        end
        checks++;
        if ({bus.player_score, bus.ai_score, bus.draw_count, bus.round_count} !==
            {expPlayer, expAi, expDraw, expRound}) begin
            errors++;
            $display("[TB] FAIL pd_counters got p=%0d a=%0d d=%0d r=%0d want p=%0d a=%0d d=%0d r=%0d",
                     bus.player_score, bus.ai_score, bus.draw_count, bus.round_count,
                     expPlayer, expAi, expDraw, expRound);
        end
        checks++;
        if (bus.outcome !== 2'b00) begin
            errors++; $display("[TB] FAIL pd_outcome_hold got %b want 00", bus.outcome);
        end
    endtask

    task automatic test_illegal();
        int reqBase;
        reqBase = aiReqCount;
        applyStimulus(MV_ILLEGAL);
        checks++;
        if ({bus.illegal_move, bus.ai_req} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL illegal_pulse got illegal=%b req=%b want illegal=1 req=0",
                     bus.illegal_move, bus.ai_req);
        end
        step(3);
        checks++;
        if (bus.illegal_move !== 1'b0 || aiReqCount != reqBase) begin
            errors++;
            $display("[TB] FAIL illegal_after got illegal=%b reqs=%0d want illegal=0 reqs=%0d",
                     bus.illegal_move, aiReqCount, reqBase);
        end
        checks++;
        if (bus.round_count !== expRound) begin
            errors++; $display("[TB] FAIL illegal_rounds got %0d want %0d", bus.round_count, expRound);
        end
    endtask

    task automatic test_timeout();
        int waited;
        exp_t e;
        applyStimulus(MV_PAPER);
        pushRound(MV_PAPER, MV_ROCK);
        bus.ai_valid = 1'b1;
        bus.ai_choice = MV_ILLEGAL;
        waited = 0;
        while (bus.ai_timeout !== 1'b1 && waited < 40) begin
            step(1);
            waited++;
        end
        bus.ai_valid = 1'b0;
        bus.ai_choice = 2'b00;
        checks++;
        if (waited != 16) begin
            errors++; $display("[TB] FAIL timeout_cycles got %0d want 16", waited);
        end
        waitComb(20, waited);
        checks++;
        if (waited != 1) begin
            errors++; $display("[TB] FAIL timeout_comb_latency got %0d want 1", waited);
        end
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if ({bus.combination, bus.outcome} !== {e.comb, e.outc}) begin
                errors++;
                $display("[TB] FAIL timeout_result got comb=%b out=%b want comb=%b out=%b",
                         bus.combination, bus.outcome, e.comb, e.outc);
            end
        end
        checks++;
        if (bus.player_score !== expPlayer) begin
            errors++; $display("[TB] FAIL timeout_score got %0d want %0d", bus.player_score, expPlayer);
        end
        step(1);
    endtask

    task automatic test_abort_reset();
        int cvBase, reqBase;
        applyStimulus(MV_ROCK);
        step(1);
        reset = 1'b1;
        bus.ai_valid = 1'b1;
        bus.ai_choice = MV_PAPER;
        step(1);
        reset = 1'b0;
        bus.ai_valid = 1'b0;
        clearModel();
        cvBase = cvCount;
        reqBase = aiReqCount;
        step(6);
        checks++;
        if (cvCount != cvBase || aiReqCount != reqBase) begin
            errors++;
            $display("[TB] FAIL abort_reset_pulses got cv=%0d req=%0d want cv=%0d req=%0d",
                     cvCount, aiReqCount, cvBase, reqBase);
        end
        checks++;
        if ({bus.player_score, bus.ai_score, bus.draw_count, bus.round_count} !== 32'd0) begin
            errors++;
            $display("[TB] FAIL abort_reset_counters got %h want 0",
                     {bus.player_score, bus.ai_score, bus.draw_count, bus.round_count});
        end
    endtask

    task automatic test_abort_new_game();
        int cvBase, reqBase;
        bus.commit = 1'b1;
        bus.player_move = MV_SCISSOR;
        step(1);
        checks++;
        if (bus.ai_req !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_ng_req got %b want 1", bus.ai_req);
        end
        bus.new_game = 1'b1;
        bus.ai_valid = 1'b1;
        bus.ai_choice = MV_PAPER;
        step(1);
        bus.new_game = 1'b0;
        bus.ai_valid = 1'b0;
        clearModel();
        cvBase = cvCount;
        reqBase = aiReqCount;
        step(6);
        checks++;
        if (cvCount != cvBase || aiReqCount != reqBase || bus.round_count !== expRound) begin
            errors++;
            $display("[TB] FAIL abort_ng_held got cv=%0d req=%0d rounds=%0d want cv=%0d req=%0d rounds=%0d",
                     cvCount, aiReqCount, bus.round_count, cvBase, reqBase, expRound);
        end
        bus.commit = 1'b0;
        step(1);
        bus.commit = 1'b1;
        bus.new_game = 1'b1;
        step(1);
        bus.new_game = 1'b0;
        bus.commit = 1'b0;
        checks++;
        if (bus.ai_req !== 1'b0) begin
            errors++; $display("[TB] FAIL ng_beats_rise got req=%b want 0", bus.ai_req);
        end
        step(2);
    endtask

    task automatic test_game_over();
        int waited, reqBase, cvBase;
        exp_t e;
        pulseNewGame();
        clearModel();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(MV_ROCK);
            pushRound(MV_ROCK, MV_SCISSOR);
            answerAi(MV_SCISSOR, i % 3);
            waitComb(20, waited);
            checks++;
            if (bus.comb_valid !== 1'b1) begin
                errors++; $display("[TB] FAIL go_comb_valid round %0d got 0 want 1", i);
            end
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checks++;
                if ({bus.combination, bus.outcome, bus.player_score} !== {e.comb, e.outc, expPlayer}) begin
                    errors++;
                    $display("[TB] FAIL go_result round %0d got comb=%b out=%b score=%0d want comb=%b out=%b score=%0d",
                             i, bus.combination, bus.outcome, bus.player_score, e.comb, e.outc, expPlayer);
                end
            end
            step(1);
            checks++;
            if (bus.game_over !== (i == 9)) begin
                errors++;
                $display("[TB] FAIL go_level round %0d got %b want %b", i, bus.game_over, (i == 9));
            end
        end
        reqBase = aiReqCount;
        cvBase = cvCount;
        applyStimulus(MV_ROCK);
        step(5);
        checks++;
        if (aiReqCount != reqBase || cvCount != cvBase || bus.round_count !== 8'd10 ||
            bus.game_over !== 1'b1) begin
            errors++;
            $display("[TB] FAIL go_ignored got req=%0d cv=%0d rounds=%0d over=%b want req=%0d cv=%0d rounds=10 over=1",
                     aiReqCount, cvCount, bus.round_count, bus.game_over, reqBase, cvBase);
        end
        pulseNewGame();
        clearModel();
        checks++;
        if ({bus.player_score, bus.ai_score, bus.draw_count, bus.round_count,
             bus.combination, bus.outcome, bus.game_over} !== 39'd0) begin
            errors++;
            $display("[TB] FAIL go_new_game got %h want 0", {bus.player_score, bus.ai_score,
                     bus.draw_count, bus.round_count, bus.combination, bus.outcome, bus.game_over});
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.commit = 1'b0;
        bus.new_game = 1'b0;
        bus.player_move = 2'b00;
        bus.ai_choice = 2'b00;
        bus.ai_valid = 1'b0;
        @(posedge clock); #1;
        test_reset();
        test_first_round();
        test_player_and_draw();
        test_illegal();
        test_timeout();
        test_abort_reset();
        test_abort_new_game();
        test_game_over();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
